// File: rtl/irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// irq_ctrl_if -- signal bundle between the interrupt controller, the
// peripherals' request/ack lines and the core/CSR trap port.
//
//   irq_req_i  : level-sensitive request lines (peripherals -> controller)
//   mie_i      : CSR mie value, low NUM_IRQ bits mask the lines
//   int_rst_i  : one-cycle pulse when mret retires (core -> controller)
//   int_o      : one-cycle trap strobe / CSR trap-write bit
//   mcause_o   : cause value for the CSR
//   irq_ack_o  : one-hot, one-cycle acknowledge of the serviced line
//   busy_o     : controller is in TRAP or SERVE
//
// The slave modport is the controller's view; the master modport is the
// view of whatever drives requests and mret (system side or a testbench).
// ---------------------------------------------------------------------------
interface irq_ctrl_if #(
  parameter int NUM_IRQ = 16
);
  logic [NUM_IRQ-1:0] irq_req_i;
  logic [31:0]        mie_i;
  logic               int_rst_i;
  logic               int_o;
  logic [31:0]        mcause_o;
  logic [NUM_IRQ-1:0] irq_ack_o;
  logic               busy_o;

  modport slave (
    input  irq_req_i, mie_i, int_rst_i,
    output int_o, mcause_o, irq_ack_o, busy_o
  );

  modport master (
    output irq_req_i, mie_i, int_rst_i,
    input  int_o, mcause_o, irq_ack_o, busy_o
  );
endinterface : irq_ctrl_if

// File: rtl/irq_ctrl.sv
// ---------------------------------------------------------------------------
// irq_ctrl -- machine-mode interrupt controller in front of the CSR file.
//
// Masks the request lines with mie, picks one pending line, raises a
// one-cycle trap strobe with the matching mcause, then holds that line in
// service until mret retires and acknowledges it to the peripheral.
//
// Ports:
//   clk_i   : clock (single domain)
//   rst_ni  : asynchronous active-low reset
//   bus     : irq_ctrl_if.slave (requests, mie, mret pulse, trap, cause,
//             ack, busy)
//
// Parameters:
//   NUM_IRQ      : number of request lines, 1..16
//   CAUSE_OFFSET : cause code of line 0; line k reports CAUSE_OFFSET + k
//
// Build option:
//   IRQ_CTRL_FIXED_PRIO_EN : when defined, SCAN resolves in one cycle by
//                            taking the lowest-index pending line. When
//                            undefined (default), a round-robin scan
//                            pointer walks one line per cycle.
// ---------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_IRQ      = 16,
  parameter int CAUSE_OFFSET = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  irq_ctrl_if.slave   bus
);

  localparam int            CW   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_IRQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    TRAP  = 2'd2,
    SERVE = 2'd3
  } state_e;

  state_e              state_q;
  logic [CW-1:0]       id_q;
  logic [NUM_IRQ-1:0]  pend;
  logic [CW-1:0]       sel_idx;   // line SCAN would take this cycle
  logic                sel_hit;   // SCAN takes sel_idx this cycle

  // mie bits above NUM_IRQ carry other interrupt classes; ignored here.
  logic unused_mie;
  assign unused_mie = ^bus.mie_i[31:NUM_IRQ];

  assign pend = bus.irq_req_i & bus.mie_i[NUM_IRQ-1:0];

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    return (v == LAST) ? '0 : v + CW'(1);
  endfunction

`ifdef IRQ_CTRL_FIXED_PRIO_EN
  // Priority encoder: scan from the top so the lowest set bit wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise an un-assigned path infers a latch.
    sel_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) sel_idx = CW'(i);
    end
  end
  assign sel_hit = |pend;
`else
  logic [CW-1:0] cnt_q;           // round-robin scan pointer

  assign sel_idx = cnt_q;
  assign sel_hit = pend[cnt_q];
`endif

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  // NOTE: every register, including outputs, has an async reset value so an
  // interrupted service leaves no stale strobe, ack or cause behind.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      id_q          <= '0;
      bus.int_o     <= 1'b0;
      bus.mcause_o  <= '0;
      bus.irq_ack_o <= '0;
`ifndef IRQ_CTRL_FIXED_PRIO_EN
      cnt_q         <= '0;
`endif
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      bus.int_o     <= 1'b0;
      bus.irq_ack_o <= '0;

      unique case (state_q)
        IDLE: begin
          if (|pend) state_q <= SCAN;
        end

        SCAN: begin
          if (!(|pend)) begin
            // Request withdrawn or masked before it was taken.
            state_q <= IDLE;
          end else if (sel_hit) begin
            // Strobe and cause are loaded on entry so both are valid
            // during the TRAP cycle.
            id_q         <= sel_idx;
            bus.int_o    <= 1'b1;
            bus.mcause_o <= {1'b1, 31'(CAUSE_OFFSET + int'(sel_idx))};
            state_q      <= TRAP;
          end else begin
`ifndef IRQ_CTRL_FIXED_PRIO_EN
            cnt_q <= wrap_inc(cnt_q);
`endif
          end
        end

        TRAP: begin
          // mret pulses here are ignored; service always begins.
          state_q <= SERVE;
        end

        SERVE: begin
          // Line id dropping or being masked does not abort service.
          if (bus.int_rst_i) begin
            bus.irq_ack_o[id_q] <= 1'b1;
`ifndef IRQ_CTRL_FIXED_PRIO_EN
            // Resume the scan just past the serviced line for fairness.
            cnt_q <= wrap_inc(id_q);
`endif
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = (state_q == TRAP) || (state_q == SERVE);

endmodule : irq_ctrl

// File: tb/tb_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl (NUM_IRQ=16,
// CAUSE_OFFSET=16). A table of single-line services is applied in a loop,
// followed by hand-written sequences for latency, masking, round-robin
// order, withdrawal, spurious mret and reset during service.
// Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_irq_ctrl;

  localparam int NUM_IRQ = 16;
  localparam int BUDGET  = 40;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  irq_ctrl_if #(.NUM_IRQ(NUM_IRQ)) bus ();

  irq_ctrl #(
    .NUM_IRQ      (NUM_IRQ),
    .CAUSE_OFFSET (16)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Advance until int_o is seen (at most BUDGET cycles); a timeout is
  // reported as a failed comparison.
  task automatic wait_int(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      tick();
      if (bus.int_o) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_int_seen"}, 32'(seen), 32'd1);
  endtask

  // Called in the TRAP cycle: step into SERVE, pulse mret, check the ack.
  task automatic serve(input string name, input logic [15:0] exp_ack);
    tick();
    check({name, "_busy_serve"}, 32'(bus.busy_o), 32'd1);
    bus.int_rst_i = 1'b1;
    tick();
    bus.int_rst_i = 1'b0;
    check({name, "_ack"}, 32'(bus.irq_ack_o), 32'(exp_ack));
    check({name, "_busy_after"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic do_reset();
    bus.irq_req_i = '0;
    bus.int_rst_i = 1'b0;
    rst_ni = 1'b0;
    #12;
    rst_ni = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [15:0] req;
    logic [31:0] mie;
    logic [31:0] exp_cause;
    logic [15:0] exp_ack;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] order_ack [4];

    vecs[0] = '{16'h0001, 32'h0000_FFFF, 32'h8000_0010, 16'h0001};
    vecs[1] = '{16'h8000, 32'h0000_FFFF, 32'h8000_001F, 16'h8000};
    vecs[2] = '{16'h0002, 32'hFFFF_FFFF, 32'h8000_0011, 16'h0002};
    vecs[3] = '{16'h0100, 32'h0000_0100, 32'h8000_0018, 16'h0100};
    vecs[4] = '{16'h1000, 32'h0001_1000, 32'h8000_001C, 16'h1000};
    vecs[5] = '{16'h0040, 32'h0000_FFFF, 32'h8000_0016, 16'h0040};

    bus.mie_i     = 32'h0000_FFFF;
    bus.irq_req_i = '0;
    bus.int_rst_i = 1'b0;
    #3;
    check("rst_int",    32'(bus.int_o),     32'd0);
    check("rst_ack",    32'(bus.irq_ack_o), 32'd0);
    check("rst_busy",   32'(bus.busy_o),    32'd0);
    check("rst_mcause", bus.mcause_o,       32'd0);
    do_reset();

    // Minimum latency on line 0 straight out of reset.
    bus.irq_req_i = 16'h0001;
    tick();
    check("lat_n1_int", 32'(bus.int_o), 32'd0);
    tick();
    check("lat_n2_int", 32'(bus.int_o), 32'd1);
    check("lat_mcause", bus.mcause_o, 32'h8000_0010);
    serve("lat", 16'h0001);
    bus.irq_req_i = '0;
    tick();
    check("lat_ack_one_cycle", 32'(bus.irq_ack_o), 32'd0);

    // Table of single-line services.
    do_reset();
    foreach (vecs[k]) begin
      bus.mie_i     = vecs[k].mie;
      bus.irq_req_i = vecs[k].req;
      wait_int($sformatf("vec%0d", k));
      check($sformatf("vec%0d_mcause", k), bus.mcause_o, vecs[k].exp_cause);
      serve($sformatf("vec%0d", k), vecs[k].exp_ack);
      bus.irq_req_i = '0;
      tick();
    end
    bus.mie_i = 32'h0000_FFFF;

    // Masked line stays silent, then is taken once unmasked.
    do_reset();
    begin
      bit any_int  = 1'b0;
      bit any_busy = 1'b0;
      bus.irq_req_i = 16'h0020;
      bus.mie_i     = 32'h0000_FFDF;
      for (int i = 0; i < 40; i++) begin
        tick();
        any_int  |= bus.int_o;
        any_busy |= bus.busy_o;
      end
      check("mask_no_int",  32'(any_int),  32'd0);
      check("mask_no_busy", 32'(any_busy), 32'd0);
    end
    bus.mie_i = 32'h0000_FFFF;
    wait_int("unmask");
    check("unmask_mcause", bus.mcause_o, 32'h8000_0015);
    serve("unmask", 16'h0020);
    bus.irq_req_i = '0;
    tick();

    // Lines 3 and 7 held high from a fresh scan pointer.
    do_reset();
`ifdef IRQ_CTRL_FIXED_PRIO_EN
    order_ack = '{16'h0008, 16'h0008, 16'h0008, 16'h0008};
`else
    order_ack = '{16'h0008, 16'h0080, 16'h0008, 16'h0080};
`endif
    bus.irq_req_i = 16'h0088;
    for (int s = 0; s < 4; s++) begin
      wait_int($sformatf("rr%0d", s));
      serve($sformatf("rr%0d", s), order_ack[s]);
    end
    bus.irq_req_i = '0;
    tick();
    tick();

    // One-cycle pulse on line 9 while the pointer sits at 0.
    do_reset();
    begin
      bit any_int = 1'b0;
      bus.irq_req_i = 16'h0200;
      tick();
      check("wd_scan_busy", 32'(bus.busy_o), 32'd0);
      bus.irq_req_i = '0;
      for (int i = 0; i < 20; i++) begin
        tick();
        any_int |= bus.int_o;
      end
      check("wd_no_int", 32'(any_int), 32'd0);
      check("wd_busy",   32'(bus.busy_o), 32'd0);
    end

    // mret pulses in IDLE and during TRAP must be ignored.
    do_reset();
    bus.int_rst_i = 1'b1;
    tick();
    bus.int_rst_i = 1'b0;
    check("spur_idle_ack", 32'(bus.irq_ack_o), 32'd0);
    bus.irq_req_i = 16'h0004;
    wait_int("spur");
    bus.int_rst_i = 1'b1;            // arrives in the TRAP cycle
    tick();
    bus.int_rst_i = 1'b0;
    check("spur_trap_ack",  32'(bus.irq_ack_o), 32'd0);
    check("spur_trap_busy", 32'(bus.busy_o),    32'd1);
    begin
      bit any_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        any_ack |= |bus.irq_ack_o;
      end
      check("spur_wait_ack",  32'(any_ack),     32'd0);
      check("spur_wait_busy", 32'(bus.busy_o),  32'd1);
    end
    bus.int_rst_i = 1'b1;
    tick();
    bus.int_rst_i = 1'b0;
    check("spur_real_ack", 32'(bus.irq_ack_o), 32'h0004);
    bus.irq_req_i = '0;
    tick();

    // Reset asserted in SERVE, request still held afterwards.
    do_reset();
    bus.irq_req_i = 16'h0010;
    wait_int("rst_srv");
    check("rst_srv_mcause", bus.mcause_o, 32'h8000_0014);
    tick();
    check("rst_srv_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_srv_async_busy",   32'(bus.busy_o),    32'd0);
    check("rst_srv_async_mcause", bus.mcause_o,       32'd0);
    check("rst_srv_async_int",    32'(bus.int_o),     32'd0);
    check("rst_srv_async_ack",    32'(bus.irq_ack_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    begin
      bit any_ack = 1'b0;
      bit seen    = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
        any_ack |= |bus.irq_ack_o;
        if (bus.int_o) begin
          seen = 1'b1;
          break;
        end
        tick();
      end
      check("rst_srv_retake",    32'(seen),    32'd1);
      check("rst_srv_no_ack",    32'(any_ack), 32'd0);
      check("rst_srv_re_mcause", bus.mcause_o, 32'h8000_0014);
    end
    serve("rst_srv", 16'h0010);
    bus.irq_req_i = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_irq_ctrl
